// File: rtl/tff_seq_pkg.sv
// Shared command and state encodings for the T-flip-flop counter sequencer.
package tff_seq_pkg;

  typedef enum logic [1:0] {
    OP_CONFIG = 2'd0,
    OP_START  = 2'd1,
    OP_STOP   = 2'd2,
    OP_LOAD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tff_seq_next.sv
// Next-count generator: one step of the counter in the configured direction,
// wrapping at the programmed limit. Shared by the step path and t_vec.
module tff_seq_next #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             wrap_o
);

  // Up wraps limit->0, down wraps 0->limit; limit=0 holds at 0 and always wraps.
  always_comb begin
    wrap_o       = 1'b0;
    next_count_o = count_i;
    if (!dir_i) begin
      wrap_o       = (count_i == limit_i);
      next_count_o = wrap_o ? '0 : count_i + 1'b1;
    end else begin
      wrap_o       = (count_i == '0);
      next_count_o = wrap_o ? limit_i : count_i - 1'b1;
    end
  end

endmodule

// File: rtl/tff_counter_sequencer.sv
// Command-driven sequencer for a bank of T flip-flop counter cells.
// Holds the architectural count and emits the per-bit toggle vector so the
// external T-cell bank always tracks the registered count.
module tff_counter_sequencer
  import tff_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RST_LIMIT = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic             cmd_oneshot,
  input  logic             count_en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(RST_LIMIT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             oneshot_q, oneshot_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] next_count;
  logic             wrap;
  logic             accept;
  logic             step;
  op_e              op;

  tff_seq_next #(.WIDTH(WIDTH)) u_next (
    .count_i      (count_q),
    .limit_i      (limit_q),
    .dir_i        (dir_q),
    .next_count_o (next_count),
    .wrap_o       (wrap)
  );

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q != S_DONE);
  assign accept    = cmd_valid & cmd_ready;
  // An accepted command always pre-empts a counting step on the same edge.
  assign step      = (state_q == S_RUN) & count_en & ~accept;
  assign t_vec     = step ? (count_q ^ next_count) : '0;
  assign count     = count_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign tc        = tc_q;
  assign err       = err_q;

  // Next-state: command decode has priority over stepping; flags default low.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    dir_d     = dir_q;
    oneshot_d = oneshot_q;
    tc_d      = 1'b0;
    err_d     = 1'b0;
    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (accept) begin
      unique case (op)
        OP_CONFIG: begin
          if (state_q == S_IDLE) begin
            limit_d   = cmd_data;
            dir_d     = cmd_dir;
            oneshot_d = cmd_oneshot;
            if (count_q > cmd_data) count_d = cmd_data;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_START: if (state_q == S_IDLE) state_d = S_RUN;
        OP_STOP:  if (state_q == S_RUN)  state_d = S_IDLE;
        OP_LOAD: begin
          if (cmd_data <= limit_q) begin
            count_d = cmd_data;
          end else begin
            count_d = limit_q;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (step) begin
      count_d = next_count;
      if (wrap) begin
        tc_d = 1'b1;
        if (oneshot_q) state_d = S_DONE;
      end
    end
  end

  // State, configuration and registered pulse flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      limit_q   <= LIMIT_RST;
      dir_q     <= 1'b0;
      oneshot_q <= 1'b0;
      tc_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      dir_q     <= dir_d;
      oneshot_q <= oneshot_d;
      tc_q      <= tc_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_tff_counter_sequencer.sv
// Self-checking bench for tff_counter_sequencer: directed scenarios followed
// by randomized commands, all compared against an arithmetic reference model.
module tb_tff_counter_sequencer;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         cmd_dir;
  logic         cmd_oneshot;
  logic         count_en;
  logic [W-1:0] count;
  logic [W-1:0] t_vec;
  logic         busy;
  logic         tc;
  logic         done;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = running, 2 = done
  int m_mode, m_count, m_limit, m_dir, m_oneshot, m_tc, m_err;

  tff_counter_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .cmd_dir     (cmd_dir),
    .cmd_oneshot (cmd_oneshot),
    .count_en    (count_en),
    .count       (count),
    .t_vec       (t_vec),
    .busy        (busy),
    .tc          (tc),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_limit = MASK; m_dir = 0; m_oneshot = 0;
    m_tc = 0; m_err = 0;
  endtask

  // One step as modular arithmetic over the period limit+1.
  function automatic int ref_next(input int c, input int lim, input int d);
    int p;
    p = lim + 1;
    if (d == 0) return (c + 1) % p;
    return (c + p - 1) % p;
  endfunction

  function automatic int ref_wraps(input int c, input int lim, input int d);
    if (d == 0) return ((c + 1) == (lim + 1)) ? 1 : 0;
    return (c == 0) ? 1 : 0;
  endfunction

  function automatic int ref_stepping();
    int acc;
    acc = (cmd_valid === 1'b1) && (m_mode != 2);
    return (m_mode == 1 && count_en === 1'b1 && !acc) ? 1 : 0;
  endfunction

  task automatic check_outputs();
    int exp_t;
    exp_t = ref_stepping() ? (m_count ^ ref_next(m_count, m_limit, m_dir)) & MASK : 0;
    chk("count",     32'(count),     32'(m_count));
    chk("busy",      32'(busy),      32'(m_mode == 1));
    chk("done",      32'(done),      32'(m_mode == 2));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_mode != 2));
    chk("tc",        32'(tc),        32'(m_tc));
    chk("err",       32'(err),       32'(m_err));
    chk("t_vec",     32'(t_vec),     32'(exp_t));
  endtask

  task automatic model_advance();
    int data;
    int n_tc, n_err;
    n_tc = 0; n_err = 0;
    data = int'(cmd_data);
    if (m_mode == 2) begin
      m_mode = 0;
    end else if (cmd_valid === 1'b1) begin
      case (cmd_op)
        2'd0: if (m_mode == 0) begin
          m_limit = data; m_dir = int'(cmd_dir); m_oneshot = int'(cmd_oneshot);
          if (m_count > data) m_count = data;
        end else n_err = 1;
        2'd1: if (m_mode == 0) m_mode = 1;
        2'd2: if (m_mode == 1) m_mode = 0;
        default: if (data <= m_limit) m_count = data;
                 else begin m_count = m_limit; n_err = 1; end
      endcase
    end else if (m_mode == 1 && count_en === 1'b1) begin
      if (ref_wraps(m_count, m_limit, m_dir) != 0) begin
        n_tc = 1;
        if (m_oneshot != 0) m_mode = 2;
      end
      m_count = ref_next(m_count, m_limit, m_dir);
    end
    m_tc = n_tc; m_err = n_err;
  endtask

  // Called at posedge+1 with inputs set: check, predict, cross the edge.
  task automatic run_cycle();
    #1;
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input int data, input logic d,
                        input logic os, input logic en);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = W'(data);
    cmd_dir = d; cmd_oneshot = os; count_en = en;
    run_cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    cmd_dir = 1'b0; cmd_oneshot = 1'b0; count_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_flags", {29'd0, tc, done, err}, 32'd0);
    rst = 1'b1;

    // Free-running up count to 9
    do_cmd(2'd0, 9, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      count_en = 1'b1;
      #1;
      if (m_count == 7) chk("t_vec_at_7", 32'(t_vec), 32'hF);
      run_cycle();
    end
    count_en = 1'b0;
    do_cmd(2'd2, 0, 1'b0, 1'b0, 1'b0);

    // One-shot down count from 2 with limit 5
    do_cmd(2'd0, 5, 1'b1, 1'b1, 1'b0);
    do_cmd(2'd3, 2, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd1, 0, 1'b0, 1'b0, 1'b0);
    count_en = 1'b1;
    for (int i = 0; i < 8; i++) run_cycle();
    chk("oneshot_final_count", 32'(count), 32'd5);
    chk("oneshot_final_busy",  32'(busy),  32'd0);
    count_en = 1'b0;

    // Stall behaviour: up, limit 9, enable toggling
    do_cmd(2'd0, 9, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd3, 0, 1'b0, 1'b0, 1'b0);
    do_cmd(2'd1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      count_en = (i % 2 == 0);
      run_cycle();
    end
    chk("stall_count", 32'(count), 32'd4);

    // Illegal commands while running, then STOP on a wrap edge
    do_cmd(2'd3, 12, 1'b0, 1'b0, 1'b1);
    chk("load_clamp", 32'(count), 32'd9);
    do_cmd(2'd0, 3, 1'b1, 1'b1, 1'b1);
    chk("config_in_run_cnt", 32'(count), 32'd9);
    do_cmd(2'd2, 0, 1'b0, 1'b0, 1'b1);
    run_cycle();
    chk("stop_on_wrap_cnt", 32'(count), 32'd9);

    // Asynchronous reset in the middle of a run
    do_cmd(2'd1, 0, 1'b0, 1'b0, 1'b1);
    run_cycle();
    run_cycle();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_flags", {29'd0, tc, done, err}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_cmd(2'd1, 0, 1'b0, 1'b0, 1'b0);
    count_en = 1'b1;
    for (int i = 0; i < 18; i++) run_cycle();
    do_cmd(2'd2, 0, 1'b0, 1'b0, 1'b0);

    // Randomized commands and enables
    for (int i = 0; i < 400; i++) begin
      cmd_valid   = ($urandom_range(0, 3) == 0);
      cmd_op      = 2'($urandom_range(0, 3));
      cmd_data    = W'($urandom_range(0, MASK));
      cmd_dir     = 1'($urandom_range(0, 1));
      cmd_oneshot = ($urandom_range(0, 3) == 0);
      count_en    = ($urandom_range(0, 3) != 0);
      run_cycle();
    end
    cmd_valid = 1'b0;
    run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_counter_sequencer.md
Name: tff_counter_sequencer

Overview:
- Controller that sequences a WIDTH-bit synchronous counter built from T flip-flop cells.
- Accepts commands over a valid/ready handshake: configure, start, stop, load.
- Holds the architectural count and drives a per-bit toggle vector (t_vec) into the external T-cell bank.
- Flags terminal count, one-shot completion and illegal commands; sits between the control/test logic and the counter datapath.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- RST_LIMIT, 2**WIDTH-1, wrap limit loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  0=CONFIG, 1=START, 2=STOP, 3=LOAD.
- cmd_data  in  WIDTH  limit (CONFIG) or load value (LOAD).
- cmd_dir  in  1  CONFIG only: 0=up, 1=down.
- cmd_oneshot  in  1  CONFIG only: 1=stop after first terminal count.
- count_en  in  1  step qualifier while running (stall when 0).
- count  out  WIDTH  current count (registered).
- t_vec  out  WIDTH  toggle inputs for the T-cell bank: count XOR next_count.
- busy  out  1  state==RUN.
- tc  out  1  one-cycle pulse, registered, on the edge where the count wraps.
- done  out  1  one-cycle pulse when a one-shot run completes.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, limit=RST_LIMIT, dir=up, oneshot=0.
  - tc=done=err=0, cmd_ready=1.
- States:
  - IDLE: count holds; t_vec=0.
  - RUN: steps when count_en=1 and no command is accepted that cycle.
  - DONE: lasts exactly one cycle; done=1, cmd_ready=0; next state is IDLE.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready.
  - cmd_ready = (state!=DONE).
  - Each accepted command takes effect on that edge.
  - A step never occurs on an edge where a command is accepted; the command has priority.
- CONFIG:
  - In IDLE: limit←cmd_data, dir←cmd_dir, oneshot←cmd_oneshot. If count>new limit, count←new limit.
  - In RUN: ignored, err=1 next cycle.
- START: IDLE→RUN; no-op in RUN.
- STOP: RUN→IDLE, count holds; no-op in IDLE.
- LOAD:
  - Any non-DONE state; state unchanged.
  - count←cmd_data if cmd_data≤limit; otherwise count←limit and err=1.
- Step, up: count==limit → count←0, tc=1; else count+1.
- Step, down: count==0 → count←limit, tc=1; else count−1.
- One-shot: on the wrapping step with oneshot=1, the count wraps, tc=1 and state→DONE. Next cycle done=1, then IDLE.
- t_vec is combinational from registered state:
  - equals count^next_count when RUN & count_en & !(cmd_valid&cmd_ready), else 0;
  - the T-cell bank state therefore always equals count.
- Width rules:
  - All arithmetic is modulo 2**WIDTH; limit compares are unsigned.
  - limit=0 → every step holds count at 0 and pulses tc.
- Reset mid-run: immediate return to the reset values; no done or tc pulse is produced.

Decomposition:
- Package tff_seq_pkg holds:
  - the cmd_op enum (OP_CONFIG, OP_START, OP_STOP, OP_LOAD);
  - the state enum (S_IDLE, S_RUN, S_DONE).
- One sub-module, tff_seq_next: purely combinational, inputs count/limit/dir, outputs next_count and wrap. It is shared by the step logic and the t_vec generation.
- The FSM, config registers and flag pulses stay in the top module.

Test Plan:
- Reset then CONFIG limit=9, up, free-run; START; count_en=1 for 12 cycles → count 0..9,0,1; tc high only on the 9→0 edge; t_vec at count=7 is 4'b1111.
- CONFIG limit=5, down, oneshot; LOAD 2; START → count 2,1,0,5; tc on the 0→5 edge; DONE with done=1 and cmd_ready=0 for one cycle; then IDLE, busy=0, count stays 5.
- RUN with count_en toggling 1,0,1 → count advances only on enabled cycles; t_vec=0 during the stall.
- In RUN at count=4: LOAD 12 with limit=9 → count=9, err=1; CONFIG issued in RUN → config unchanged, err=1; STOP on the same cycle a wrap would occur → no step, no tc, IDLE.
- Assert rst low asynchronously mid-run, not on a clock edge → count=0, busy=0, outputs cleared before the next edge; limit returns to 15.
